wb_dma_arbiter: RTL and testbench



---
 rtl/wb_dma_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_dma_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dma_arbiter.sv
// Wishbone bus ownership controller: CPU versus up to four round-robin DMA masters.
// Define DMA_TIMEOUT_EN to add the ack-timeout watchdog (tmo_ack_o / tmo_err_o).
module wb_dma_arbiter #(
  parameter int unsigned NDMA     = 2,
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CPU_MIN  = 2,
  parameter int unsigned TMO      = 255
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            cpu_cyc_i,
  input  logic            wb_ack_i,
  output logic            cpu_gnt_o,
  input  logic [NDMA-1:0] dma_req_i,
  input  logic [NDMA-1:0] dma_cyc_i,
  output logic [NDMA-1:0] dma_gnt_o,
  output logic [1:0]      dma_sel_o,
  output logic            dma_act_o,
  output logic            tmo_ack_o,
  output logic            tmo_err_o
);

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CPUH_W = 4;
  localparam int unsigned TMO_W  = 8;
  localparam int unsigned MAXDMA = 4;

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [CPUH_W-1:0] CPUH_MIN = CPUH_W'(CPU_MIN);
  localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(TMO);

  typedef enum logic [1:0] {S_CPU, S_WAITC, S_DMA, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CPUH_W-1:0]   cpuh_q, cpuh_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NDMA-1:0]     gnt_q, gnt_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                act_q, act_d;

  logic [MAXDMA-1:0]   req_ext, cyc_ext;
  logic                any_req, req_k, cyc_k, boundary, ack_k;
  logic [SEL_W-1:0]    rr_idx, rr_win;
  logic                rr_found;

`ifdef DMA_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tmo_ack_q, tmo_ack_d;
  logic                tmo_err_q, tmo_err_d;
`else
  logic                unused_tmo;
  assign unused_tmo = ^TMO_LIM;
`endif

  assign req_ext  = MAXDMA'(dma_req_i);
  assign cyc_ext  = MAXDMA'(dma_cyc_i);
  assign any_req  = |dma_req_i;
  assign req_k    = req_ext[sel_q];
  assign cyc_k    = cyc_ext[sel_q];
  // A granted master's Wishbone cycle ends when it drops cyc or receives its ack.
  assign boundary = ~cyc_k | wb_ack_i;
`ifdef DMA_TIMEOUT_EN
  assign ack_k    = (wb_ack_i | tmo_ack_q) & cyc_k;
`else
  assign ack_k    = wb_ack_i & cyc_k;
`endif

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CPU;
      hold_q    <= '0;
      cpuh_q    <= CPUH_MIN;
      last_q    <= SEL_W'(NDMA - 1);
      sel_q     <= '0;
      gnt_q     <= '0;
      cpu_gnt_q <= 1'b1;
      act_q     <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      tmo_q     <= '0;
      tmo_ack_q <= 1'b0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpuh_q    <= cpuh_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      cpu_gnt_q <= cpu_gnt_d;
      act_q     <= act_d;
`ifdef DMA_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tmo_ack_q <= tmo_ack_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cpuh_d   = cpuh_q;
    last_d   = last_q;
    sel_d    = sel_q;
    rr_idx   = '0;
    rr_win   = last_q;
    rr_found = 1'b0;
`ifdef DMA_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_ack_d = 1'b0;
    tmo_err_d = tmo_err_q;
`endif

    // Round-robin: first requester after the last-granted index.
    for (int unsigned i = 1; i <= NDMA; i++) begin
      rr_idx = SEL_W'((32'(last_q) + i) % NDMA);
      if (!rr_found && req_ext[rr_idx]) begin
        rr_win   = rr_idx;
        rr_found = 1'b1;
      end
    end

    case (state_q)
      S_CPU: begin
        if (cpuh_q != {CPUH_W{1'b1}}) cpuh_d = cpuh_q + CPUH_W'(1);
        if (any_req && (cpuh_q >= CPUH_MIN)) begin
          state_d = (!cpu_cyc_i || wb_ack_i) ? S_DMA : S_WAITC;
        end
      end
      S_WAITC: begin
        if (!any_req)                    state_d = S_CPU;
        else if (!cpu_cyc_i || wb_ack_i) state_d = S_DMA;
      end
      S_DMA: begin
        if (ack_k && (hold_q != {HOLD_W{1'b1}})) hold_d = hold_q + HOLD_W'(1);
        if (boundary && (!req_k || (hold_d >= HOLD_LIM))) state_d = S_GAP;
`ifdef DMA_TIMEOUT_EN
        if (wb_ack_i)                                     tmo_d = '0;
        else if (cyc_k && (tmo_q != {TMO_W{1'b1}}))       tmo_d = tmo_q + TMO_W'(1);
        if (cyc_k && !wb_ack_i && (tmo_d == TMO_LIM)) begin
          tmo_ack_d = 1'b1;
          tmo_err_d = 1'b1;
          state_d   = S_GAP;
        end
`endif
      end
      S_GAP: begin
        state_d = S_CPU;
        cpuh_d  = '0;
      end
      default: state_d = S_CPU;
    endcase

    if ((state_d == S_DMA) && (state_q != S_DMA)) begin
      sel_d  = rr_win;
      last_d = rr_win;
      hold_d = '0;
`ifdef DMA_TIMEOUT_EN
      tmo_d  = '0;
`endif
    end

    cpu_gnt_d = (state_d == S_CPU) || (state_d == S_WAITC);
    act_d     = (state_d == S_DMA);
    gnt_d     = act_d ? NDMA'(MAXDMA'(1) << sel_d) : '0;
  end

  assign cpu_gnt_o = cpu_gnt_q;
  assign dma_gnt_o = gnt_q;
  assign dma_sel_o = sel_q;
  assign dma_act_o = act_q;
`ifdef DMA_TIMEOUT_EN
  assign tmo_ack_o = tmo_ack_q;
  assign tmo_err_o = tmo_err_q;
`else
  assign tmo_ack_o = 1'b0;
  assign tmo_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Scoreboard bench for wb_dma_arbiter: expected grants and tenure lengths are queued
// as stimulus is applied and checked when the arbiter grants and releases the bus.
module tb_wb_dma_arbiter;

  localparam int NDMA     = 2;
  localparam int HOLD_MAX = 4;
  localparam int CPU_MIN  = 2;
  localparam int TMO      = 10;
`ifdef DMA_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            clk_p = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpu_cyc_i = 1'b0;
  logic            wb_ack_i = 1'b0;
  logic            cpu_gnt_o;
  logic [NDMA-1:0] dma_req_i = '0;
  logic [NDMA-1:0] dma_cyc_i = '0;
  logic [NDMA-1:0] dma_gnt_o;
  logic [1:0]      dma_sel_o;
  logic            dma_act_o;
  logic            tmo_ack_o;
  logic            tmo_err_o;

  wb_dma_arbiter #(
    .NDMA(NDMA), .HOLD_MAX(HOLD_MAX), .CPU_MIN(CPU_MIN), .TMO(TMO)
  ) dut (
    .clk_p(clk_p), .rst_n(rst_n), .cpu_cyc_i(cpu_cyc_i), .wb_ack_i(wb_ack_i),
    .cpu_gnt_o(cpu_gnt_o), .dma_req_i(dma_req_i), .dma_cyc_i(dma_cyc_i),
    .dma_gnt_o(dma_gnt_o), .dma_sel_o(dma_sel_o), .dma_act_o(dma_act_o),
    .tmo_ack_o(tmo_ack_o), .tmo_err_o(tmo_err_o)
  );

  always #5 clk_p = ~clk_p;

  int              n_vec = 0;
  int              n_err = 0;
  logic [NDMA-1:0] exp_gnt_q[$];
  int              exp_len_q[$];
  logic [NDMA-1:0] prev_gnt = '0;
  int              ack_cnt = 0;
  int              cpu_run = 0;
  bit              gap_chk = 1'b0;
  bit              manual = 1'b0;
  bit              cpu_ack = 1'b0;
  int              rem[NDMA];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample on the falling edge, score grant events, then drive the masters.
  task automatic cycle();
    @(negedge clk_p);
    if (prev_gnt != '0 && wb_ack_i && (dma_cyc_i & prev_gnt) != '0) ack_cnt++;
    if (dma_gnt_o != '0 && prev_gnt == '0) begin
      if (gap_chk) check("cpu_min", 32'(cpu_run >= CPU_MIN), 32'd1);
      gap_chk = 1'b0;
      ack_cnt = 0;
      if (exp_gnt_q.size() == 0) check("gnt_unexp", 32'(dma_gnt_o), 32'd0);
      else check("gnt_idx", 32'(dma_gnt_o), 32'(exp_gnt_q.pop_front()));
    end
    if (dma_gnt_o == '0 && prev_gnt != '0) begin
      if (exp_len_q.size() == 0) check("len_unexp", 32'(exp_len_q.size()), 32'd1);
      else check("tenure_len", 32'(ack_cnt), 32'(exp_len_q.pop_front()));
      gap_chk = 1'b1;
      cpu_run = 0;
      if (!manual)
        for (int i = 0; i < NDMA; i++)
          if (prev_gnt[i] && rem[i] > 0) rem[i]--;
    end
    if (cpu_gnt_o) cpu_run++;
    check("excl", 32'(cpu_gnt_o & dma_act_o), 32'd0);
    check("onehot", 32'($onehot0(dma_gnt_o)), 32'd1);
    prev_gnt = dma_gnt_o;
    if (!manual) begin
      for (int i = 0; i < NDMA; i++) dma_req_i[i] = (rem[i] > 0);
      dma_cyc_i = dma_gnt_o;
      wb_ack_i  = (dma_gnt_o != '0) || (cpu_cyc_i && cpu_ack);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((exp_len_q.size() != 0 || !cpu_gnt_o) && n < budget) begin
      cycle();
      n++;
    end
    check("idle_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_act(input int budget);
    int n = 0;
    while (!dma_act_o && n < budget) begin
      cycle();
      n++;
    end
    check("act_budget", 32'(dma_act_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with both masters requesting; the first grant must go to master 0.
    rem[0] = 2;
    rem[1] = 2;
    dma_req_i = '1;
    repeat (2) cycle();
    check("rst_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
    check("rst_dma_gnt", 32'(dma_gnt_o), 32'd0);
    check("rst_act", 32'(dma_act_o), 32'd0);
    check("rst_sel", 32'(dma_sel_o), 32'd0);
    check("rst_tmo_ack", 32'(tmo_ack_o), 32'd0);
    check("rst_tmo_err", 32'(tmo_err_o), 32'd0);
    for (int t = 0; t < 4; t++) begin
      exp_gnt_q.push_back((t % 2 == 0) ? 2'b01 : 2'b10);
      exp_len_q.push_back(HOLD_MAX);
    end
    rst_n = 1'b1;
    cycle();
    check("first_gnt", 32'(dma_gnt_o), 32'h1);
    check("first_cpu", 32'(cpu_gnt_o), 32'd0);
    check("first_sel", 32'(dma_sel_o), 32'd0);
    run_until_idle(200);

    // CPU cycle in flight when master 1 requests: grant follows the CPU ack.
    cpu_cyc_i = 1'b1;
    cpu_ack   = 1'b0;
    repeat (3) cycle();
    exp_gnt_q.push_back(2'b10);
    exp_len_q.push_back(HOLD_MAX);
    rem[1] = 1;
    dma_req_i = 2'b10;
    for (int t = 0; t < 3; t++) begin
      cycle();
      check("waitc_cpu", 32'(cpu_gnt_o), 32'd1);
      check("waitc_nognt", 32'(dma_gnt_o), 32'd0);
    end
    cpu_ack  = 1'b1;
    wb_ack_i = 1'b1;
    cycle();
    check("waitc_gnt", 32'(dma_gnt_o), 32'h2);
    check("waitc_cpuoff", 32'(cpu_gnt_o), 32'd0);
    check("waitc_sel", 32'(dma_sel_o), 32'd1);
    cpu_ack   = 1'b0;
    cpu_cyc_i = 1'b0;
    run_until_idle(100);

    // Master drops its request mid-cycle: grant held until the ack, then GAP, then CPU.
    manual = 1'b1;
    exp_gnt_q.push_back(2'b01);
    exp_len_q.push_back(1);
    dma_req_i = 2'b01;
    dma_cyc_i = '0;
    wb_ack_i  = 1'b0;
    wait_act(20);
    dma_cyc_i = 2'b01;
    repeat (2) cycle();
    check("cyc_hold", 32'(dma_gnt_o), 32'h1);
    dma_req_i = '0;
    cycle();
    check("drop_hold", 32'(dma_gnt_o), 32'h1);
    wb_ack_i = 1'b1;
    cycle();
    check("gap_gnt", 32'(dma_gnt_o), 32'd0);
    check("gap_act", 32'(dma_act_o), 32'd0);
    check("gap_cpu", 32'(cpu_gnt_o), 32'd0);
    wb_ack_i  = 1'b0;
    dma_cyc_i = '0;
    cycle();
    check("cpu_back", 32'(cpu_gnt_o), 32'd1);

    // Stuck master: watchdog fires after TMO clocks, or the tenure persists without it.
    exp_gnt_q.push_back(2'b01);
    exp_len_q.push_back(0);
    dma_req_i = 2'b01;
    wait_act(20);
    dma_cyc_i = 2'b01;
    wb_ack_i  = 1'b0;
    if (TMO_ON) begin
      exp_gnt_q.push_back(2'b01);
      exp_len_q.push_back(0);
    end
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("stuck_tmo_ack", 32'(tmo_ack_o), 32'(TMO_ON && n == TMO));
      check("stuck_tmo_err", 32'(tmo_err_o), 32'(TMO_ON && n >= TMO));
      check("stuck_gnt", 32'(dma_gnt_o), (!TMO_ON || n < TMO) ? 32'h1 : 32'h0);
      check("stuck_cpu", 32'(cpu_gnt_o), 32'(TMO_ON && n >= TMO + 1));
    end
    wait_act(20);
    check("err_sticky", 32'(tmo_err_o), 32'(TMO_ON));

    // Asynchronous reset in the middle of a tenure.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cpu", 32'(cpu_gnt_o), 32'd1);
    check("arst_gnt", 32'(dma_gnt_o), 32'd0);
    check("arst_act", 32'(dma_act_o), 32'd0);
    check("arst_sel", 32'(dma_sel_o), 32'd0);
    check("arst_tmo_ack", 32'(tmo_ack_o), 32'd0);
    check("arst_tmo_err", 32'(tmo_err_o), 32'd0);
    dma_req_i = '0;
    dma_cyc_i = '0;
    wb_ack_i  = 1'b0;
    repeat (2) cycle();
    check("rst_hold_cpu", 32'(cpu_gnt_o), 32'd1);
    rst_n = 1'b1;
    cycle();
    check("post_rst_cpu", 32'(cpu_gnt_o), 32'd1);
    check("post_rst_act", 32'(dma_act_o), 32'd0);
    check("sb_empty", 32'(exp_gnt_q.size() + exp_len_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
